// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 block-RAM arbiter: return-path owner
// encoding and starvation-counter sizing.
package mips32_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int STARVE_MAX = 15;
  localparam int STARVE_W   = 4;

  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
    return (v == STARVE_W'(STARVE_MAX)) ? v : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mips32_rr_starve.sv
// Two-input read-port grant: the high-priority requester wins unless the
// low-priority one has been denied maxWait or more consecutive cycles.
module mips32_rr_starve
  import mips32_mem_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                reqHi,
  input  logic                reqLo,
  input  logic [STARVE_W-1:0] maxWait,
  output logic                grantHi,
  output logic                grantLo
);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                lo_forced;

  assign lo_forced = (starve_q >= maxWait);
  assign grantHi   = reqHi & ~(reqLo & lo_forced);
  assign grantLo   = reqLo & (~reqHi | lo_forced);

  // The counter only measures an unbroken run of denials; any I win or idle
  // cycle restarts it.
  always_comb begin
    starve_d = '0;
    if (reqLo && !grantLo) starve_d = starve_inc(starve_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/mips32_ram_arbiter.sv
// Shares one registered-address BRAM read port between instruction fetch (I)
// and load/store (D); D writes go straight to the dedicated write port.
module mips32_ram_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AWIDTH   = 10,
  parameter int DWIDTH   = 32,
  parameter int LANES    = 4,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iReq,
  input  logic [AWIDTH-1:0] iAddr,
  output logic              iAck,
  output logic              iValid,
  output logic [DWIDTH-1:0] iData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [AWIDTH-1:0] dAddr,
  input  logic [DWIDTH-1:0] dWdata,
  input  logic [LANES-1:0]  dLane,
  output logic              dAck,
  output logic              dValid,
  output logic [DWIDTH-1:0] dData,
  output logic [AWIDTH-1:0] ramReadAddr,
  output logic              ramReadEnable,
  input  logic [DWIDTH-1:0] ramReadData,
  output logic [AWIDTH-1:0] ramWriteAddr,
  output logic [DWIDTH-1:0] ramWriteData,
  output logic [LANES-1:0]  ramWriteLane,
  output logic              ramWriteEnable
);

  logic   wr_req, rd_d_req;
  logic   grant_hi, grant_lo, grant_i, grant_d;
  owner_e owner_q, owner_d;

  assign wr_req   = reset & dReq & dWe;
  assign rd_d_req = dReq & ~dWe;

  mips32_rr_starve u_arb (
    .clock   (clock),
    .reset   (reset),
    .reqHi   (rd_d_req),
    .reqLo   (iReq),
    .maxWait (STARVE_W'(MAX_WAIT)),
    .grantHi (grant_hi),
    .grantLo (grant_lo)
  );

  // Gating with reset keeps the RAM and both requesters quiet while held in reset.
  assign grant_d = reset & grant_hi;
  assign grant_i = reset & grant_lo;

  assign iAck          = grant_i;
  assign dAck          = wr_req | grant_d;
  assign ramReadEnable = grant_i | grant_d;
  assign ramReadAddr   = grant_d ? dAddr : iAddr;

  assign ramWriteEnable = wr_req;
  assign ramWriteAddr   = dAddr;
  assign ramWriteData   = dWdata;

  generate
    if (LANES > 1) begin : g_lanes
      assign ramWriteLane = reset ? dLane : '0;
    end else begin : g_word
      assign ramWriteLane = {LANES{reset}};
    end
  endgenerate

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding a value and no latch is inferred.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant_i)      owner_d = OWN_I;
    else if (grant_d) owner_d = OWN_D;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  // Read data is shared; only the matching valid qualifies it.
  assign iValid = (owner_q == OWN_I);
  assign dValid = (owner_q == OWN_D);
  assign iData  = ramReadData;
  assign dData  = ramReadData;

endmodule

// File: tb/tb_mips32_ram_arbiter.sv
// Directed bench for mips32_ram_arbiter with a behavioural BRAM, a reference
// memory/grant model and a scoreboard of expected return-path results.
module tb_mips32_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [1:0]  own;
    logic [31:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iReq = 1'b0, dReq = 1'b0, dWe = 1'b0;
  logic [AW-1:0] iAddr = '0, dAddr = '0;
  logic [DW-1:0] dWdata = '0;
  logic [3:0]    dLane = '0;
  logic          lane1_in = 1'b0;
  logic          iAck, iValid, dAck, dValid;
  logic [DW-1:0] iData, dData;
  logic [AW-1:0] ramReadAddr, ramWriteAddr;
  logic          ramReadEnable, ramWriteEnable;
  logic [DW-1:0] ramReadData, ramWriteData;
  logic [3:0]    ramWriteLane;

  logic          iAck_1, iValid_1, dAck_1, dValid_1;
  logic [DW-1:0] iData_1, dData_1;
  logic [AW-1:0] ramReadAddr_1, ramWriteAddr_1;
  logic          ramReadEnable_1, ramWriteEnable_1;
  logic [DW-1:0] ramReadData_1, ramWriteData_1;
  logic          ramWriteLane_1;

  int   vectors = 0;
  int   miscompares = 0;
  int   model_starve = 0;
  logic obs_iack;
  exp_t sb[$];

  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_raddr_q;
  logic          ram_load = 1'b0;

  always #5 clock = ~clock;

  mips32_ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LANES(4), .MAX_WAIT(3)) u_dut (
    .clock(clock), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iValid(iValid), .iData(iData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dLane(dLane),
    .dAck(dAck), .dValid(dValid), .dData(dData),
    .ramReadAddr(ramReadAddr), .ramReadEnable(ramReadEnable), .ramReadData(ramReadData),
    .ramWriteAddr(ramWriteAddr), .ramWriteData(ramWriteData),
    .ramWriteLane(ramWriteLane), .ramWriteEnable(ramWriteEnable)
  );

  assign ramReadData_1 = '0;

  mips32_ram_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LANES(1), .MAX_WAIT(3)) u_dut1 (
    .clock(clock), .reset(reset),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck_1), .iValid(iValid_1), .iData(iData_1),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dLane(lane1_in),
    .dAck(dAck_1), .dValid(dValid_1), .dData(dData_1),
    .ramReadAddr(ramReadAddr_1), .ramReadEnable(ramReadEnable_1), .ramReadData(ramReadData_1),
    .ramWriteAddr(ramWriteAddr_1), .ramWriteData(ramWriteData_1),
    .ramWriteLane(ramWriteLane_1), .ramWriteEnable(ramWriteEnable_1)
  );

  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    if (a == 10'h020) return 32'h1122_3344;
    return {6'h2A, a, 6'h15, a};
  endfunction

  // Behavioural BRAM: registered read address, asynchronous array read.
  always @(posedge clock) begin
    if (ram_load) begin
      for (int k = 0; k < (1 << AW); k++) ram_mem[k] <= init_word(AW'(k));
    end else if (ramWriteEnable) begin
      for (int l = 0; l < 4; l++)
        if (ramWriteLane[l]) ram_mem[ramWriteAddr][8*l +: 8] <= ramWriteData[8*l +: 8];
    end
    if (ramReadEnable) ram_raddr_q <= ramReadAddr;
  end
  assign ramReadData = ram_mem[ram_raddr_q];

  // Requesters must hold request and address until acknowledged.
  logic          i_pend_q = 1'b0, d_pend_q = 1'b0;
  logic [AW-1:0] i_addr_q, d_addr_q;
  always @(posedge clock) begin
    if (reset && i_pend_q)
      assert (iReq === 1'b1 && iAddr === i_addr_q)
        else begin miscompares++; $error("FAIL i_req_stable: observed %h expected %h", iAddr, i_addr_q); end
    if (reset && d_pend_q)
      assert (dReq === 1'b1 && dAddr === d_addr_q)
        else begin miscompares++; $error("FAIL d_req_stable: observed %h expected %h", dAddr, d_addr_q); end
    i_pend_q <= reset && iReq && !iAck;
    d_pend_q <= reset && dReq && !dAck;
    i_addr_q <= iAddr;
    d_addr_q <= dAddr;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // One arbitration cycle: drive, check acks against the model, queue the
  // expected return, then compare the return one cycle after the grant.
  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr,
                      input logic dw, input logic [AW-1:0] da, input logic [31:0] wd,
                      input logic [3:0] ln, input string tag);
    logic ci, cd, gi, gd, wr;
    exp_t e;
    @(negedge clock);
    iReq = ir; iAddr = ia; dReq = dr; dWe = dw; dAddr = da; dWdata = wd; dLane = ln;
    #1;
    ci = ir;
    cd = dr & ~dw;
    wr = dr & dw;
    gd = cd & ~(ci && model_starve >= 3);
    gi = ci & ~gd;
    obs_iack = iAck;
    check({tag, "_iAck"}, 32'(iAck), 32'(gi));
    check({tag, "_dAck"}, 32'(dAck), 32'(gd | wr));
    check({tag, "_rdEn"}, 32'(ramReadEnable), 32'(gi | gd));
    if (gi | gd) check({tag, "_rdAddr"}, 32'(ramReadAddr), 32'(gi ? ia : da));
    check({tag, "_wrEn"}, 32'(ramWriteEnable), 32'(wr));
    if (wr) begin
      check({tag, "_wrLane"}, 32'(ramWriteLane), 32'(ln));
      for (int l = 0; l < 4; l++)
        if (ln[l]) ref_mem[da][8*l +: 8] = wd[8*l +: 8];
    end
    e.own  = gi ? 2'd1 : (gd ? 2'd2 : 2'd0);
    e.data = ref_mem[gi ? ia : da];
    sb.push_back(e);
    model_starve = (ci && !gi) ? ((model_starve < 15) ? model_starve + 1 : 15) : 0;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_iValid"}, 32'(iValid), 32'(e.own == 2'd1));
      check({tag, "_dValid"}, 32'(dValid), 32'(e.own == 2'd2));
      if (e.own == 2'd1) check({tag, "_iData"}, iData, e.data);
      if (e.own == 2'd2) check({tag, "_dData"}, dData, e.data);
    end
  endtask

  initial begin
    logic [7:0] pattern;
    for (int k = 0; k < (1 << AW); k++) ref_mem[k] = init_word(AW'(k));

    // Reset with requests active: everything must stay quiet.
    ram_load = 1'b1;
    iReq = 1'b1; dReq = 1'b1; dWe = 1'b1; dLane = 4'hF;
    @(posedge clock);
    @(negedge clock);
    ram_load = 1'b0;
    check("rst_iValid", 32'(iValid), 32'd0);
    check("rst_dValid", 32'(dValid), 32'd0);
    check("rst_iAck", 32'(iAck), 32'd0);
    check("rst_dAck", 32'(dAck), 32'd0);
    check("rst_wrEn", 32'(ramWriteEnable), 32'd0);
    check("rst_wrLane", 32'(ramWriteLane), 32'd0);
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    reset = 1'b1;

    // I-only streaming reads.
    for (int a = 'h010; a <= 'h013; a++) step(1'b1, AW'(a), 1'b0, 1'b0, '0, '0, 4'h0, "ifetch");

    // Partial-lane write then read back.
    step(1'b0, '0, 1'b1, 1'b1, 10'h020, 32'hDEAD_BEEF, 4'b0011, "dwr_lane");
    step(1'b0, '0, 1'b1, 1'b0, 10'h020, '0, 4'h0, "drd_lane");
    check("drd_lane_literal", dData, 32'h1122_BEEF);

    // Continuous contention: D,D,D,I repeating, then D finishes alone.
    pattern = 8'b1000_1000;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 10'h040, 1'b1, 1'b0, 10'h041, '0, 4'h0, "contend");
      check("contend_pattern", 32'(obs_iack), 32'(pattern[k]));
      check("contend_starve_le_max", 32'(u_dut.u_arb.starve_q <= 4'd3), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 10'h041, '0, 4'h0, "contend_tail");

    // Write concurrent with an I read of a neighbour, then read it back.
    step(1'b1, 10'h031, 1'b1, 1'b1, 10'h030, 32'hCAFE_F00D, 4'hF, "wr_vs_i");
    check("wr_vs_i_old", iData, init_word(10'h031));
    step(1'b1, 10'h030, 1'b0, 1'b0, '0, '0, 4'h0, "raw_next");
    check("raw_next_literal", iData, 32'hCAFE_F00D);

    // Read granted in the same cycle as a write to the same address.
    step(1'b1, 10'h050, 1'b1, 1'b1, 10'h050, 32'h1234_5678, 4'hF, "raw_same");
    check("raw_same_literal", iData, 32'h1234_5678);

    // Reset between a D read grant and its return.
    @(negedge clock);
    iReq = 1'b0; dReq = 1'b1; dWe = 1'b0; dAddr = 10'h020; dLane = 4'hF;
    #1;
    check("mid_rst_dAck", 32'(dAck), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    iReq = 1'b1; iAddr = 10'h010;
    #1;
    check("mid_rst_dValid", 32'(dValid), 32'd0);
    check("mid_rst_iAck", 32'(iAck), 32'd0);
    check("mid_rst_dAck_rd", 32'(dAck), 32'd0);
    check("mid_rst_rdEn", 32'(ramReadEnable), 32'd0);
    dWe = 1'b1;
    #1;
    check("mid_rst_dAck_wr", 32'(dAck), 32'd0);
    check("mid_rst_wrEn", 32'(ramWriteEnable), 32'd0);
    check("mid_rst_wrLane", 32'(ramWriteLane), 32'd0);
    @(negedge clock);
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0;
    reset = 1'b1;
    model_starve = 0;
    step(1'b0, '0, 1'b1, 1'b0, 10'h020, '0, 4'h0, "reissue");
    check("reissue_literal", dData, 32'h1122_BEEF);

    // Whole-word configuration ignores dLane.
    lane1_in = 1'b0;
    step(1'b0, '0, 1'b1, 1'b1, 10'h060, 32'h0BAD_F00D, 4'h0, "lanes1");
    check("lanes1_wrLane", 32'(ramWriteLane_1), 32'd1);
    check("lanes1_wrEn", 32'(ramWriteEnable_1), 32'd1);
    check("lanes1_wrData", ramWriteData_1, 32'h0BAD_F00D);
    check("lanes1_wrAddr", 32'(ramWriteAddr_1), 32'h060);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
